// File: rtl/pc_sequencer_if.sv
// Handshake and instruction-address bundle between the program sequencer
// and its environment (launch/halt control, branch-target table, fetch).
interface pc_sequencer_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            Halt;
    logic            BranchEn;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCounter;
    logic [1:0]      ProgState;
    logic            Busy;
    logic            Done;
    logic            Timeout;

    // Environment side: launches programs, decodes halts, returns targets.
    modport master (
        output Start,
        output Halt,
        output BranchEn,
        output Target,
        input  ProgCounter,
        input  ProgState,
        input  Busy,
        input  Done,
        input  Timeout
    );

    // Sequencer side.
    modport slave (
        input  Start,
        input  Halt,
        input  BranchEn,
        input  Target,
        output ProgCounter,
        output ProgState,
        output Busy,
        output Done,
        output Timeout
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and program sequencer. Runs programs 1 -> 2 -> 3 -> 1,
// one per Start/Done handshake, and selects the active program bank of the
// branch-target table through ProgState. A watchdog forcibly ends any
// program that runs for WDOG_LIMIT cycles and leaves a sticky Timeout flag.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no program running; ProgCounter holds, waits for Start
//  RUN   | program ProgState executing; PC steps, branches or ends
module pc_sequencer #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] P1_START   = 10'd0,
    parameter logic [PC_W-1:0] P2_START   = 10'd256,
    parameter logic [PC_W-1:0] P3_START   = 10'd512,
    parameter logic [15:0]     WDOG_LIMIT = 16'd65535
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] WDOG_LAST = WDOG_LIMIT - 16'd1;

    state_t          state;
    logic [PC_W-1:0] prog_counter;
    logic [1:0]      prog_state;
    logic [1:0]      next_prog;
    logic [15:0]     wdog_cnt;
    logic            busy;
    logic            done;
    logic            timeout;

    logic            wdog_hit;
    logic [PC_W-1:0] launch_addr;
    logic [1:0]      prog_after;

    // Watchdog terminal count and launch-address / program-rotation decode.
    always_comb begin
        wdog_hit = (wdog_cnt == WDOG_LAST);
        case (next_prog)
            2'b10:   launch_addr = P2_START;
            2'b11:   launch_addr = P3_START;
            default: launch_addr = P1_START;
        endcase
        case (next_prog)
            2'b01:   prog_after = 2'b10;
            2'b10:   prog_after = 2'b11;
            default: prog_after = 2'b01;
        endcase
    end

    // Sequencer FSM with registered outputs; Halt outranks the watchdog,
    // which outranks a taken branch, which outranks sequential fetch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            prog_counter <= '0;
            prog_state   <= 2'b00;
            next_prog    <= 2'b01;
            wdog_cnt     <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state        <= RUN;
                        prog_state   <= next_prog;
                        prog_counter <= launch_addr;
                        wdog_cnt     <= 16'd0;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.Halt || wdog_hit) begin
                        state      <= IDLE;
                        prog_state <= 2'b00;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        next_prog  <= prog_after;
                        // A genuine Halt on the last allowed cycle is not a timeout.
                        if (!bus.Halt) begin
                            timeout <= 1'b1;
                        end
                    end else begin
                        if (bus.BranchEn) begin
                            prog_counter <= bus.Target;
                        end else begin
                            prog_counter <= prog_counter + 1'b1;
                        end
                        wdog_cnt <= wdog_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ProgCounter = prog_counter;
    assign bus.ProgState   = prog_state;
    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.Timeout     = timeout;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-parameter instance for the
// sequencing/branch/reset behaviour and a WDOG_LIMIT=8 instance for the
// watchdog. Inputs change 1 ns after a rising edge; outputs are checked there.
module tb_pc_sequencer;

    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;

    pc_sequencer_if #(.PC_W(10)) m_if ();
    pc_sequencer_if #(.PC_W(10)) w_if ();

    pc_sequencer u_main (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (m_if)
    );

    pc_sequencer #(.WDOG_LIMIT(16'd8)) u_wd (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (w_if)
    );

    // 10 ns system clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_m(input string tag, input int pc, input int ps,
                         input int busy, input int done, input int to);
        check({tag, ".pc"},   32'(m_if.ProgCounter), 32'(pc));
        check({tag, ".ps"},   32'(m_if.ProgState),   32'(ps));
        check({tag, ".busy"}, 32'(m_if.Busy),        32'(busy));
        check({tag, ".done"}, 32'(m_if.Done),        32'(done));
        check({tag, ".to"},   32'(m_if.Timeout),     32'(to));
    endtask

    task automatic chk_w(input string tag, input int pc, input int ps,
                         input int busy, input int done, input int to);
        check({tag, ".pc"},   32'(w_if.ProgCounter), 32'(pc));
        check({tag, ".ps"},   32'(w_if.ProgState),   32'(ps));
        check({tag, ".busy"}, 32'(w_if.Busy),        32'(busy));
        check({tag, ".done"}, 32'(w_if.Done),        32'(done));
        check({tag, ".to"},   32'(w_if.Timeout),     32'(to));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset = 1'b1;
        m_if.Start = 1'b0; m_if.Halt = 1'b0; m_if.BranchEn = 1'b0; m_if.Target = 10'd0;
        w_if.Start = 1'b0; w_if.Halt = 1'b0; w_if.BranchEn = 1'b0; w_if.Target = 10'd0;
        tick();
        tick();
        chk_m("reset", 0, 0, 0, 0, 0);
        chk_w("wd_reset", 0, 0, 0, 0, 0);
        Reset = 1'b0;

        // Launch program 1 and step sequentially.
        m_if.Start = 1'b1;
        tick();
        m_if.Start = 1'b0;
        chk_m("launch1", 0, 1, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_m("step", i, 1, 1, 0, 0);
        end

        // Restart from reset so program 1 is next again; branch at PC=3.
        Reset = 1'b1;
        tick();
        chk_m("reset_run", 0, 0, 0, 0, 0);
        Reset = 1'b0;
        m_if.Start = 1'b1;
        tick();
        m_if.Start = 1'b0;
        chk_m("launch1b", 0, 1, 1, 0, 0);
        tick(); tick(); tick();
        chk_m("at3", 3, 1, 1, 0, 0);
        m_if.BranchEn = 1'b1; m_if.Target = 10'd40;
        tick();
        chk_m("br40", 40, 1, 1, 0, 0);
        m_if.BranchEn = 1'b0; m_if.Target = 10'd999;
        tick();
        chk_m("seq41", 41, 1, 1, 0, 0);
        m_if.BranchEn = 1'b1; m_if.Target = 10'd6;
        tick();
        m_if.BranchEn = 1'b0;
        tick();
        chk_m("at7", 7, 1, 1, 0, 0);

        // Halt and BranchEn together: Halt wins, PC holds.
        m_if.Halt = 1'b1; m_if.BranchEn = 1'b1; m_if.Target = 10'd100;
        tick();
        chk_m("halt_br", 7, 0, 0, 1, 0);
        m_if.Halt = 1'b0; m_if.BranchEn = 1'b0;
        tick();
        chk_m("after_done", 7, 0, 0, 0, 0);

        // Halt/BranchEn ignored in IDLE.
        m_if.Halt = 1'b1; m_if.BranchEn = 1'b1; m_if.Target = 10'd300;
        tick();
        chk_m("idle_ign", 7, 0, 0, 0, 0);
        m_if.Halt = 1'b0; m_if.BranchEn = 1'b0;

        // Program 2; Start held into RUN is ignored.
        m_if.Start = 1'b1;
        tick();
        chk_m("launch2", 256, 2, 1, 0, 0);
        tick();
        chk_m("start_in_run", 257, 2, 1, 0, 0);
        m_if.Start = 1'b0; m_if.Halt = 1'b1;
        tick();
        chk_m("done2", 257, 0, 0, 1, 0);

        // Start during the Done cycle launches program 3.
        m_if.Halt = 1'b0; m_if.Start = 1'b1;
        tick();
        m_if.Start = 1'b0;
        chk_m("launch3", 512, 3, 1, 0, 0);
        tick();
        chk_m("step513", 513, 3, 1, 0, 0);
        m_if.Halt = 1'b1;
        tick();
        chk_m("done3", 513, 0, 0, 1, 0);
        m_if.Halt = 1'b0; m_if.Start = 1'b1;
        tick();
        m_if.Start = 1'b0;
        chk_m("wrap_prog1", 0, 1, 1, 0, 0);
        m_if.Halt = 1'b1;
        tick();
        m_if.Halt = 1'b0;
        chk_m("done1c", 0, 0, 0, 1, 0);

        // Program 2: PC wraps 1023 -> 0, then reset at PC=260.
        m_if.Start = 1'b1;
        tick();
        m_if.Start = 1'b0;
        chk_m("launch2b", 256, 2, 1, 0, 0);
        m_if.BranchEn = 1'b1; m_if.Target = 10'd1023;
        tick();
        chk_m("br1023", 1023, 2, 1, 0, 0);
        m_if.BranchEn = 1'b0;
        tick();
        chk_m("pc_wrap", 0, 2, 1, 0, 0);
        m_if.BranchEn = 1'b1; m_if.Target = 10'd260;
        tick();
        chk_m("br260", 260, 2, 1, 0, 0);
        m_if.BranchEn = 1'b0; Reset = 1'b1;
        tick();
        chk_m("mid_reset", 0, 0, 0, 0, 0);
        Reset = 1'b0;
        tick();
        chk_m("no_done", 0, 0, 0, 0, 0);
        m_if.Start = 1'b1;
        tick();
        m_if.Start = 1'b0;
        chk_m("relaunch1", 0, 1, 1, 0, 0);

        // Watchdog instance: 8 RUN cycles then forced halt.
        w_if.Start = 1'b1;
        tick();
        w_if.Start = 1'b0;
        chk_w("wd_launch", 0, 1, 1, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk_w("wd_run", i, 1, 1, 0, 0);
        end
        tick();
        chk_w("wd_fire", 7, 0, 0, 1, 1);
        tick();
        chk_w("wd_sticky", 7, 0, 0, 0, 1);
        w_if.Start = 1'b1;
        tick();
        w_if.Start = 1'b0;
        chk_w("wd_launch2", 256, 2, 1, 0, 1);
        w_if.Halt = 1'b1;
        tick();
        w_if.Halt = 1'b0;
        chk_w("wd_normal_halt", 256, 0, 0, 1, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_w("wd_clear", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
